instr_fetch_unit: RTL and testbench

//  Upstream of the control FSM. On a fetch strobe, reads the instruction at PC from word-wide instruction memory.

---
 rtl/cpu_pkg.sv | 41 ++++
 rtl/instr_field_decode.sv | 29 ++
 rtl/instr_fetch_unit.sv | 126 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, instruction field layout, NOP and
// fetch FSM state encoding.
package cpu_pkg;

    localparam int OPC_W   = 3;
    localparam int REG_W   = 3;
    localparam int IMM_W   = 7;

    localparam int OPC_LSB = 13;
    localparam int RD_LSB  = 10;
    localparam int RS1_LSB = 7;
    localparam int RS2_LSB = 4;
    localparam int IMM_LSB = 0;

    localparam logic [OPC_W-1:0] OP_ADD  = 3'b000;
    localparam logic [OPC_W-1:0] OP_SUB  = 3'b001;
    localparam logic [OPC_W-1:0] OP_ADDI = 3'b010;
    localparam logic [OPC_W-1:0] OP_SUBI = 3'b011;
    localparam logic [1:0]       OP_BR_PFX = 2'b10;
    localparam logic [1:0]       OP_FP_PFX = 2'b11;

    localparam logic [15:0] NOP_INSTR = 16'h0000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic logic is_branch(input logic [OPC_W-1:0] op);
        return op[OPC_W-1:1] == OP_BR_PFX;
    endfunction

    function automatic logic is_fp(input logic [OPC_W-1:0] op);
        return op[OPC_W-1:1] == OP_FP_PFX;
    endfunction

    function automatic logic uses_imm(input logic [OPC_W-1:0] op);
        return (op == OP_ADDI) || (op == OP_SUBI);
    endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational split of an instruction word into opcode, register fields and
// a sign-extended immediate.
module instr_field_decode
    import cpu_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int DATA_W  = 16
) (
    input  logic [INSTR_W-1:0] instr_i,
    output logic [OPC_W-1:0]   opcode_o,
    output logic [REG_W-1:0]   rd_o,
    output logic [REG_W-1:0]   rs1_o,
    output logic [REG_W-1:0]   rs2_o,
    output logic [DATA_W-1:0]  imm_o
);

    logic [IMM_W-1:0] imm7;

    // imm7 overlaps rs2; both views are always produced and the consumer picks.
    always_comb begin
        opcode_o = instr_i[OPC_LSB +: OPC_W];
        rd_o     = instr_i[RD_LSB  +: REG_W];
        rs1_o    = instr_i[RS1_LSB +: REG_W];
        rs2_o    = instr_i[RS2_LSB +: REG_W];
        imm7     = instr_i[IMM_LSB +: IMM_W];
        imm_o    = {{(DATA_W-IMM_W){imm7[IMM_W-1]}}, imm7};
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one outstanding read to word-wide instruction memory,
// single-entry instruction register, timeout and misalignment reporting.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int PC_W    = 13,
    parameter int INSTR_W = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PC_W-1:0]    PC,
    input  logic               fetch_req,
    output logic               mem_req,
    output logic [PC_W-3:0]    mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               mem_valid,
    output logic [OPC_W-1:0]   Opcode,
    output logic [REG_W-1:0]   rd,
    output logic [REG_W-1:0]   rs1,
    output logic [REG_W-1:0]   rs2,
    output logic [DATA_W-1:0]  imm,
    output logic               instr_valid,
    output logic               busy,
    output logic               fetch_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [PC_W-3:0]    addr_q,  addr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               err_q,   err_d;
    logic               misal_q, misal_d;

    // A misaligned fetch still passes through REQ (with the request
    // suppressed) so it reports two cycles after the strobe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        err_d   = err_q;
        misal_d = misal_q;
        case (state_q)
            ST_IDLE: begin
                if (fetch_req) begin
                    addr_d  = PC[PC_W-1:2];
                    cnt_d   = '0;
                    state_d = ST_REQ;
                    if (PC[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        instr_d = INSTR_W'(NOP_INSTR);
                        misal_d = 1'b1;
                    end else begin
                        misal_d = 1'b0;
                    end
                end
            end
            ST_REQ: begin
                cnt_d   = '0;
                state_d = misal_q ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                // Data arriving on the final wait cycle beats the timeout.
                if (mem_valid) begin
                    instr_d = mem_rdata;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    instr_d = INSTR_W'(NOP_INSTR);
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                misal_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            instr_q <= '0;
            err_q   <= 1'b0;
            misal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            err_q   <= err_d;
            misal_q <= misal_d;
        end
    end

    assign mem_req     = (state_q == ST_REQ) && !misal_q;
    assign mem_addr    = addr_q;
    assign instr_valid = (state_q == ST_DONE);
    assign busy        = (state_q != ST_IDLE);
    assign fetch_err   = err_q;

    instr_field_decode #(
        .INSTR_W (INSTR_W),
        .DATA_W  (DATA_W)
    ) u_decode (
        .instr_i  (instr_q),
        .opcode_o (Opcode),
        .rd_o     (rd),
        .rs1_o    (rs1),
        .rs2_o    (rs2),
        .imm_o    (imm)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: aligned, misaligned, timeout, busy
// overlap, back-to-back and mid-fetch reset scenarios.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic [12:0] PC;
    logic        fetch_req;
    logic        mem_req;
    logic [10:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_valid;
    logic [2:0]  Opcode, rd, rs1, rs2;
    logic [15:0] imm;
    logic        instr_valid, busy, fetch_err;

    int checks   = 0;
    int failures = 0;

    instr_fetch_unit #(
        .PC_W(13), .INSTR_W(16), .DATA_W(16), .TIMEOUT(15)
    ) dut (
        .clk(clk), .reset(reset), .PC(PC), .fetch_req(fetch_req),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_valid(mem_valid), .Opcode(Opcode), .rd(rd), .rs1(rs1),
        .rs2(rs2), .imm(imm), .instr_valid(instr_valid), .busy(busy),
        .fetch_err(fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout required=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Strobe a fetch in the current cycle (cycle 0) and act as memory.
    // delay: cycles from mem_req to mem_valid (<=0 means never answer).
    // dup_cyc: cycle at which a second fetch_req with dup_pc is driven.
    task automatic do_fetch(input logic [12:0] pc, input logic [15:0] rdata,
                            input int delay, input int dup_cyc, input logic [12:0] dup_pc,
                            output int iv_cyc, output int nreq, output logic [10:0] addr_seen);
        int req_cyc;
        req_cyc   = -1000;
        iv_cyc    = -1;
        nreq      = 0;
        addr_seen = '0;
        PC        = pc;
        fetch_req = 1'b1;
        for (int c = 1; c <= 40 && iv_cyc < 0; c++) begin
            tick();
            fetch_req = 1'b0;
            mem_valid = 1'b0;
            if (mem_req) begin
                nreq++;
                req_cyc   = c;
                addr_seen = mem_addr;
            end
            if (delay > 0 && c == req_cyc + delay) begin
                mem_valid = 1'b1;
                mem_rdata = rdata;
            end
            if (c == dup_cyc) begin
                PC        = dup_pc;
                fetch_req = 1'b1;
            end
            if (instr_valid) iv_cyc = c;
        end
        mem_valid = 1'b0;
        fetch_req = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    int          iv, nq, seen;
    logic [10:0] a;

    initial begin
        reset     = 1'b0;
        PC        = '0;
        fetch_req = 1'b0;
        mem_rdata = '0;
        mem_valid = 1'b0;
        tick();
        tick();
        chk("rst_mem_req", {31'd0, mem_req}, 0);
        chk("rst_mem_addr", {21'd0, mem_addr}, 0);
        chk("rst_opcode", {29'd0, Opcode}, 0);
        chk("rst_imm", {16'd0, imm}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_err", {31'd0, fetch_err}, 0);
        chk("rst_iv", {31'd0, instr_valid}, 0);
        reset = 1'b1;
        tick();

        // Aligned fetch, response two cycles after the request.
        do_fetch(13'h0008, 16'h5A7F, 2, -1, '0, iv, nq, a);
        chk("al_iv_cycle", iv, 4);
        chk("al_nreq", nq, 1);
        chk("al_addr", {21'd0, a}, 32'h002);
        chk("al_opcode", {29'd0, Opcode}, 32'b010);
        chk("al_rd", {29'd0, rd}, 32'b110);
        chk("al_rs1", {29'd0, rs1}, 32'b100);
        chk("al_rs2", {29'd0, rs2}, 32'b111);
        chk("al_imm", {16'd0, imm}, 32'hFFFF);
        chk("al_err", {31'd0, fetch_err}, 0);
        chk("al_busy_done", {31'd0, busy}, 1);
        tick();
        chk("al_busy_after", {31'd0, busy}, 0);
        chk("al_iv_after", {31'd0, instr_valid}, 0);

        // Misaligned fetch.
        do_fetch(13'h0006, 16'hFFFF, 1, -1, '0, iv, nq, a);
        chk("mis_iv_cycle", iv, 2);
        chk("mis_nreq", nq, 0);
        chk("mis_err", {31'd0, fetch_err}, 1);
        chk("mis_opcode", {29'd0, Opcode}, 0);
        chk("mis_imm", {16'd0, imm}, 0);
        tick();

        // Timeout with no response.
        do_fetch(13'h0100, 16'h0000, 0, -1, '0, iv, nq, a);
        chk("to_iv_cycle", iv, 17);
        chk("to_nreq", nq, 1);
        chk("to_err", {31'd0, fetch_err}, 1);
        chk("to_opcode", {29'd0, Opcode}, 0);
        chk("to_imm", {16'd0, imm}, 0);
        pulse_reset();
        chk("to_err_cleared", {31'd0, fetch_err}, 0);

        // Response on the last wait cycle wins over the timeout.
        do_fetch(13'h0104, 16'h8F40, 15, -1, '0, iv, nq, a);
        chk("edge_iv_cycle", iv, 17);
        chk("edge_err", {31'd0, fetch_err}, 0);
        chk("edge_opcode", {29'd0, Opcode}, 32'b100);
        chk("edge_rd", {29'd0, rd}, 32'b011);
        chk("edge_rs1", {29'd0, rs1}, 32'b110);
        chk("edge_rs2", {29'd0, rs2}, 32'b100);
        chk("edge_imm", {16'd0, imm}, 32'hFFC0);
        tick();

        // Second strobe during WAIT ignored; late response discarded.
        do_fetch(13'h0020, 16'h2C95, 3, 2, 13'h0010, iv, nq, a);
        chk("ovl_iv_cycle", iv, 5);
        chk("ovl_nreq", nq, 1);
        chk("ovl_addr", {21'd0, a}, 32'h008);
        chk("ovl_opcode", {29'd0, Opcode}, 32'b001);
        chk("ovl_rd", {29'd0, rd}, 32'b011);
        chk("ovl_imm", {16'd0, imm}, 32'h0015);
        tick();
        mem_valid = 1'b1;
        mem_rdata = 16'hFFFF;
        tick();
        mem_valid = 1'b0;
        chk("ovl_late_iv", {31'd0, instr_valid}, 0);
        chk("ovl_late_req", {31'd0, mem_req}, 0);
        chk("ovl_late_busy", {31'd0, busy}, 0);
        chk("ovl_late_imm", {16'd0, imm}, 32'h0015);
        chk("ovl_late_err", {31'd0, fetch_err}, 0);

        // Back-to-back fetches at the top of the address space and at zero.
        do_fetch(13'h1FFC, 16'h4A05, 1, -1, '0, iv, nq, a);
        chk("b2b1_iv_cycle", iv, 3);
        chk("b2b1_addr", {21'd0, a}, 32'h7FF);
        chk("b2b1_opcode", {29'd0, Opcode}, 32'b010);
        chk("b2b1_rd", {29'd0, rd}, 32'b010);
        chk("b2b1_imm", {16'd0, imm}, 32'h0005);
        tick();
        do_fetch(13'h0000, 16'hE3C1, 1, -1, '0, iv, nq, a);
        chk("b2b2_iv_cycle", iv, 3);
        chk("b2b2_nreq", nq, 1);
        chk("b2b2_addr", {21'd0, a}, 32'h000);
        chk("b2b2_opcode", {29'd0, Opcode}, 32'b111);
        chk("b2b2_rs1", {29'd0, rs1}, 32'b111);
        chk("b2b2_imm", {16'd0, imm}, 32'hFFC1);
        tick();

        // Sticky error survives a later good fetch.
        do_fetch(13'h0003, 16'h0000, 1, -1, '0, iv, nq, a);
        chk("stk_err_set", {31'd0, fetch_err}, 1);
        tick();
        do_fetch(13'h0100, 16'h5A7F, 1, -1, '0, iv, nq, a);
        chk("stk_err_hold", {31'd0, fetch_err}, 1);
        chk("stk_opcode", {29'd0, Opcode}, 32'b010);
        tick();

        // Reset asserted in the middle of WAIT.
        PC        = 13'h0040;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("mr_req_seen", {31'd0, mem_req}, 1);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("mr_busy", {31'd0, busy}, 0);
        chk("mr_addr", {21'd0, mem_addr}, 0);
        chk("mr_opcode", {29'd0, Opcode}, 0);
        chk("mr_imm", {16'd0, imm}, 0);
        chk("mr_err", {31'd0, fetch_err}, 0);
        chk("mr_iv", {31'd0, instr_valid}, 0);
        tick();
        reset = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            mem_valid = (c == 1);
            mem_rdata = 16'h5A7F;
            tick();
            if (instr_valid || mem_req || busy) seen++;
        end
        mem_valid = 1'b0;
        chk("mr_quiet_after", seen, 0);
        chk("mr_imm_after", {16'd0, imm}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
